// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with a configurable width and depth,
// selectable first-word-fall-through or registered read, level flags, and
// sticky overflow/underflow flags.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   i_data       write data
//   push         write request
//   pop          read request
//   flush        synchronous empty command; overrides push/pop
//   clr_err      clears the sticky overflow/underflow flags
//   o_data       read data
//   o_valid      o_data qualifier
//   count        number of stored entries, 0..DEPTH
//   full, empty, almost_full, almost_empty   level flags from registered count
//   overflow, underflow                      sticky error flags
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_EXP   = 4,
  parameter int FWFT       = 1,
  parameter int AF_THRESH  = (2**ADDR_EXP) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [ADDR_EXP:0]     count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_EXP;
  localparam logic [ADDR_EXP:0]   DEPTH_L = (ADDR_EXP+1)'(DEPTH);
  localparam logic [ADDR_EXP:0]   AF_L    = (ADDR_EXP+1)'(AF_THRESH);
  localparam logic [ADDR_EXP:0]   AE_L    = (ADDR_EXP+1)'(AE_THRESH);
  localparam logic [ADDR_EXP:0]   CNT_ONE = (ADDR_EXP+1)'(1);
  localparam logic [ADDR_EXP-1:0] PTR_ONE = ADDR_EXP'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_EXP-1:0]   wr_ptr;
  logic [ADDR_EXP-1:0]   rd_ptr;
  logic [ADDR_EXP:0]     cnt;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  ovf_set;
  logic                  udf_set;

  assign count        = cnt;
  assign full         = (cnt == DEPTH_L);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_L);
  assign almost_empty = (cnt <= AE_L);

  // A full FIFO still accepts a push when a pop is accepted in the same
  // cycle; an empty FIFO never accepts a pop, even alongside a push.
  assign pop_acc  = pop & ~empty & ~flush;
  assign push_acc = push & ~flush & (~full | pop_acc);
  assign ovf_set  = push & ~flush & full & ~pop_acc;
  assign udf_set  = pop & ~flush & empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_acc && !pop_acc)      cnt <= cnt + CNT_ONE;
      else if (pop_acc && !push_acc) cnt <= cnt - CNT_ONE;
    end
  end

  // A new error event takes priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= i_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Storage is never reset, so the head word is masked while empty to
      // give a defined zero on o_data during and after reset.
      always_comb begin
        o_data  = '0;
        o_valid = ~empty;
        if (!empty) o_data = mem[rd_ptr];
      end
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          o_data  <= '0;
          o_valid <= 1'b0;
        end else begin
          o_valid <= pop_acc;
          if (pop_acc) o_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = '0;
  logic       push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;

  // a: FWFT read, b: registered read; both see identical stimulus
  logic [7:0] o_data_a, o_data_b;
  logic       o_valid_a, o_valid_b;
  logic [4:0] count_a, count_b;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, udf_b;

  int unsigned total = 0;
  int unsigned bad = 0;

  // Reference model
  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_vld = 1'b0;
  logic [7:0] m_dat = '0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(8), .ADDR_EXP(4), .FWFT(1)) dut_a (
    .clk(clk), .rst(rst), .i_data(i_data), .push(push), .pop(pop),
    .flush(flush), .clr_err(clr_err), .o_data(o_data_a), .o_valid(o_valid_a),
    .count(count_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .overflow(ovf_a), .underflow(udf_a));

  param_sync_fifo #(.DATA_WIDTH(8), .ADDR_EXP(4), .FWFT(0)) dut_b (
    .clk(clk), .rst(rst), .i_data(i_data), .push(push), .pop(pop),
    .flush(flush), .clr_err(clr_err), .o_data(o_data_b), .o_valid(o_valid_b),
    .count(count_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .overflow(ovf_b), .underflow(udf_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit in_rst);
    int unsigned n;
    n = q.size();
    chk("count_a", 32'(count_a), n);
    chk("count_b", 32'(count_b), n);
    chk("full_a", 32'(full_a), 32'(n == DEPTH));
    chk("full_b", 32'(full_b), 32'(n == DEPTH));
    chk("empty_a", 32'(empty_a), 32'(n == 0));
    chk("empty_b", 32'(empty_b), 32'(n == 0));
    chk("afull_a", 32'(af_a), 32'(n >= 14));
    chk("afull_b", 32'(af_b), 32'(n >= 14));
    chk("aempty_a", 32'(ae_a), 32'(n <= 2));
    chk("aempty_b", 32'(ae_b), 32'(n <= 2));
    chk("ovf_a", 32'(ovf_a), 32'(m_ovf));
    chk("ovf_b", 32'(ovf_b), 32'(m_ovf));
    chk("udf_a", 32'(udf_a), 32'(m_udf));
    chk("udf_b", 32'(udf_b), 32'(m_udf));
    chk("valid_a", 32'(o_valid_a), 32'(n != 0));
    if (n != 0) chk("data_a", 32'(o_data_a), 32'(q[0]));
    else if (in_rst) chk("data_a_rst", 32'(o_data_a), 32'h0);
    chk("valid_b", 32'(o_valid_b), 32'(m_vld));
    chk("data_b", 32'(o_data_b), 32'(m_dat));
  endtask

  // Model advance for one clock edge with the given request set.
  task automatic model_step(input logic p, input logic o, input logic f,
                            input logic c, input logic [7:0] d);
    bit pop_ok, push_ok, set_o, set_u;
    int unsigned n;
    n = q.size();
    set_o = 1'b0;
    set_u = 1'b0;
    if (f) begin
      q.delete();
      m_vld = 1'b0;
    end else begin
      pop_ok  = o && (n > 0);
      push_ok = p && ((n < DEPTH) || pop_ok);
      set_o   = p && !push_ok;
      set_u   = o && (n == 0);
      m_vld   = pop_ok;
      if (pop_ok) m_dat = q.pop_front();
      if (push_ok) q.push_back(d);
    end
    m_ovf = set_o || (m_ovf && !c);
    m_udf = set_u || (m_udf && !c);
  endtask

  task automatic cyc(input logic p, input logic o, input logic f,
                     input logic c, input logic [7:0] d);
    @(negedge clk);
    push = p; pop = o; flush = f; clr_err = c; i_data = d;
    @(posedge clk);
    model_step(p, o, f, c, d);
    #1;
    check_all(1'b0);
  endtask

  initial begin
    // Reset state
    #1;
    check_all(1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x00..0x0F, then a 17th push overflows
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, 8'(i));
    chk("fill_full", 32'(full_a), 32'h1);
    cyc(1, 0, 0, 0, 8'hEE);
    chk("ovf_17th", 32'(ovf_a), 32'h1);
    chk("head_00", 32'(o_data_a), 32'h00);
    cyc(0, 0, 0, 1, 8'h00);

    // Simultaneous push/pop while full rewrites the vacated slot
    cyc(1, 1, 0, 0, 8'hAA);
    chk("wrap_cnt", 32'(count_a), 32'd16);
    chk("wrap_noovf", 32'(ovf_a), 32'h0);

    // Drain; the last word out is 0xAA, then one extra pop underflows
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 0, 8'h00);
    chk("drain_last", 32'(o_data_b), 32'hAA);
    cyc(0, 1, 0, 0, 8'h00);
    chk("udf_extra", 32'(udf_a), 32'h1);
    cyc(0, 0, 0, 1, 8'h00);

    // Push+pop on empty: push wins, pop flagged as underflow
    cyc(1, 1, 0, 0, 8'h55);
    chk("emp_pp_cnt", 32'(count_a), 32'd1);
    chk("emp_pp_udf", 32'(udf_a), 32'h1);
    chk("emp_pp_data", 32'(o_data_a), 32'h55);

    // Registered read, back-to-back pops
    cyc(0, 0, 1, 1, 8'h00);
    cyc(1, 0, 0, 0, 8'h11);
    cyc(1, 0, 0, 0, 8'h22);
    cyc(0, 1, 0, 0, 8'h00);
    chk("reg_rd1", 32'({o_valid_b, o_data_b}), 32'h111);
    cyc(0, 1, 0, 0, 8'h00);
    chk("reg_rd2", 32'({o_valid_b, o_data_b}), 32'h122);
    cyc(0, 0, 0, 0, 8'h00);
    chk("reg_idle", 32'({o_valid_b, o_data_b}), 32'h022);

    // Flush at count 5 overrides a coincident push
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'(8'h30 + i));
    cyc(1, 0, 1, 0, 8'h99);
    chk("flush_cnt", 32'(count_a), 32'd0);
    chk("flush_empty", 32'(empty_b), 32'h1);

    // Asynchronous reset mid-cycle at count 7
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 8'(8'h40 + i));
    cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h47);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_dat = '0;
    check_all(1'b1);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 0, 0, 8'h5A);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic p, o, f, c;
      p = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      o = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      f = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 5);
      cyc(p, o, f, c, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
